// File: rtl/ram_frame_writer.sv
// ram_frame_writer: writes valid/ready frames into the dual-clock RAM from address 0
// and holds each stored frame (with its length) until the reader acknowledges it.
module ram_frame_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_add,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    output logic              overflow,
    input  logic              frame_ack
);
    typedef enum logic [1:0] {IDLE, FILL, DROP, HOLD} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t            state, state_d;
    logic [ADDR_W:0]   cnt, cnt_d, len_d;
    logic [ADDR_W-1:0] add_d;
    logic [DATA_W-1:0] din_d;
    logic              held, we_d, ovf_d, fr_d, xfer;
    assign xfer = in_valid & in_ready;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = 1'b0;
        add_d   = ram_wr_add;
        din_d   = ram_d_in;
        ovf_d   = 1'b0;
        fr_d    = frame_ready;
        len_d   = frame_len;
        case (state)
            IDLE, FILL: if (xfer) begin
                we_d    = 1'b1;
                add_d   = cnt[ADDR_W-1:0];
                din_d   = in_data;
                cnt_d   = cnt + 1'b1;
                state_d = in_last ? HOLD : (cnt_d == FULL ? DROP : FILL);
            end
            DROP: if (xfer) begin
                ovf_d   = 1'b1;
                state_d = in_last ? HOLD : DROP;
            end
            HOLD: if (frame_ready && frame_ack) begin
                state_d = IDLE;
                cnt_d   = '0;
                fr_d    = 1'b0;
                len_d   = '0;
            end else if (held) begin
                // one settling cycle in HOLD so the final RAM write lands before frame_ready
                fr_d  = 1'b1;
                len_d = cnt;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            cnt         <= '0;
            held        <= 1'b0;
            in_ready    <= 1'b0;
            ram_we      <= 1'b0;
            ram_wr_add  <= '0;
            ram_d_in    <= '0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            held        <= state == HOLD;
            in_ready    <= state_d != HOLD;
            ram_we      <= we_d;
            ram_wr_add  <= add_d;
            ram_d_in    <= din_d;
            frame_ready <= fr_d;
            frame_len   <= len_d;
            overflow    <= ovf_d;
        end
    end
endmodule
